// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath select codes and the instruction classes produced by the decoder.
package cu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_e;

  typedef enum logic [3:0] {
    CL_R       = 4'd0,
    CL_I_ALU   = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JAL     = 4'd5,
    CL_JALR    = 4'd6,
    CL_LUI     = 4'd7,
    CL_ILLEGAL = 4'd8
  } instr_class_e;

  // funct3[2] picks the lt flag over zero; funct3[0] inverts the sense (BNE/BGE/BGEU).
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic zero, input logic lt);
    return (funct3[2] ? lt : zero) ^ funct3[0];
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational RV32I decode: classifies the instruction and derives the ALU
// operation and immediate format used while it executes.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [6:0]   i_opcode,
  input  logic [2:0]   i_funct3,
  input  logic [6:0]   i_funct7,
  output instr_class_e o_class,
  output alu_op_e      o_alucontrol,
  output imm_type_e    o_imm_type
);

  logic w_f7_zero;
  logic w_f7_alt;
  logic w_r_ok;
  logic w_shift_ok;

  assign w_f7_zero  = (i_funct7 == 7'b0000000);
  assign w_f7_alt   = (i_funct7 == 7'b0100000);
  // The alternate funct7 only exists for SUB/SRA (R) and SRAI (I).
  assign w_r_ok     = w_f7_zero || (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101));
  assign w_shift_ok = w_f7_zero || (w_f7_alt && i_funct3 == 3'b101);

  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    o_class      = CL_ILLEGAL;
    o_alucontrol = ALU_ADD;
    o_imm_type   = IMM_I;
    case (i_opcode)
      OP_R: begin
        if (w_r_ok) begin
          o_class      = CL_R;
          o_alucontrol = alu_from_funct(i_funct3, i_funct7[5]);
        end
      end
      OP_I_ALU: begin
        if ((i_funct3 != 3'b001 && i_funct3 != 3'b101) || w_shift_ok) begin
          o_class      = CL_I_ALU;
          o_alucontrol = alu_from_funct(i_funct3, (i_funct3 == 3'b101) && i_funct7[5]);
        end
      end
      OP_LOAD: begin
        if (i_funct3 == 3'b010) o_class = CL_LOAD;
      end
      OP_STORE: begin
        if (i_funct3 == 3'b010) begin
          o_class    = CL_STORE;
          o_imm_type = IMM_S;
        end
      end
      OP_BRANCH: begin
        if (i_funct3[2:1] != 2'b01) begin
          o_class      = CL_BRANCH;
          o_imm_type   = IMM_B;
          o_alucontrol = !i_funct3[2] ? ALU_SUB : (!i_funct3[1] ? ALU_SLT : ALU_SLTU);
        end
      end
      OP_JAL: begin
        o_class    = CL_JAL;
        o_imm_type = IMM_J;
      end
      OP_JALR: begin
        if (i_funct3 == 3'b000) o_class = CL_JALR;
      end
      OP_LUI: begin
        o_class      = CL_LUI;
        o_imm_type   = IMM_U;
        o_alucontrol = ALU_PASS_B;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH..WRITEBACK, waits on the memory
// ready handshake with an optional timeout, and halts in ERROR on faults.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int MEM_HANDSHAKE  = 1,
  parameter int TIMEOUT_CYCLES = 0
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        lt,
  input  logic        mem_ready,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        link,
  output logic        alusrc,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_type,
  output logic [3:0]  alucontrol,
  output logic [2:0]  state_o,
  output logic        error
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW:0] TO_LIMIT = TIMEOUT_CYCLES[CW:0];

  state_e       r_state;
  state_e       w_next;
  logic [CW-1:0] r_wait_cnt;
  logic [CW:0]  w_cnt_inc;
  instr_class_e w_class;
  alu_op_e      w_alu;
  imm_type_e    w_imm;
  logic         w_waiting;
  logic         w_ready;
  logic         w_timeout;
  logic         w_taken;
  logic         w_unused_fields;

  cu_decoder u_decoder (
    .i_opcode     (instruction[6:0]),
    .i_funct3     (instruction[14:12]),
    .i_funct7     (instruction[31:25]),
    .o_class      (w_class),
    .o_alucontrol (w_alu),
    .o_imm_type   (w_imm)
  );

  // Register and rd fields are consumed by the datapath, not by control.
  assign w_unused_fields = ^{instruction[24:15], instruction[11:7]};

  assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEMORY);
  assign w_ready   = (MEM_HANDSHAKE == 0) || mem_ready;
  assign w_taken   = branch_taken(instruction[14:12], zero, lt);
  assign w_cnt_inc = {1'b0, r_wait_cnt} + {{CW{1'b0}}, 1'b1};
  // The count includes the current cycle, so a ready in this cycle still wins.
  assign w_timeout = (TIMEOUT_CYCLES > 0) && (MEM_HANDSHAKE != 0) && w_waiting &&
                     !mem_ready && (w_cnt_inc == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (w_waiting && !mem_ready) begin
      r_wait_cnt <= w_cnt_inc[CW-1:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:    w_next = ST_FETCH;
      ST_FETCH: begin
        if (w_ready)        w_next = ST_DECODE;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_DECODE: w_next = (w_class == CL_ILLEGAL) ? ST_ERROR : ST_EXECUTE;
      ST_EXECUTE: begin
        case (w_class)
          CL_R, CL_I_ALU, CL_LUI:      w_next = ST_WRITEBACK;
          CL_LOAD, CL_STORE:           w_next = ST_MEMORY;
          CL_BRANCH, CL_JAL, CL_JALR:  w_next = ST_FETCH;
          default:                     w_next = ST_ERROR;
        endcase
      end
      ST_MEMORY: begin
        if (w_ready)        w_next = (w_class == CL_LOAD) ? ST_WRITEBACK : ST_FETCH;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_WRITEBACK: w_next = ST_FETCH;
      ST_ERROR:     w_next = ST_ERROR;
      default:      w_next = ST_ERROR;
    endcase
  end

  always_comb begin
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    link       = 1'b0;
    alusrc     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = PC_PLUS4;
    imm_type   = IMM_I;
    alucontrol = ALU_ADD;
    error      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        memread = 1'b1;
        if (w_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_sel   = PC_PLUS4;
        end
      end
      ST_EXECUTE: begin
        imm_type   = w_imm;
        alucontrol = w_alu;
        case (w_class)
          CL_I_ALU, CL_LOAD, CL_STORE, CL_LUI: alusrc = 1'b1;
          CL_BRANCH: begin
            if (w_taken) begin
              pc_write = 1'b1;
              pc_sel   = PC_BRANCH;
            end
          end
          CL_JAL: begin
            regwrite = 1'b1;
            link     = 1'b1;
            pc_write = 1'b1;
            pc_sel   = PC_BRANCH;
          end
          CL_JALR: begin
            regwrite = 1'b1;
            link     = 1'b1;
            pc_write = 1'b1;
            pc_sel   = PC_JALR;
          end
          default: ;
        endcase
      end
      ST_MEMORY: begin
        memread  = (w_class == CL_LOAD);
        memwrite = (w_class == CL_STORE);
      end
      ST_WRITEBACK: begin
        regwrite = 1'b1;
        memtoreg = (w_class == CL_LOAD);
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle state/control vectors for
// each instruction class, wait handling, timeout, illegal decode and reset.
module tb_multicycle_control_unit;

  // Observation vector layout:
  // [20:18] state, [17] regwrite, [16] memread, [15] memwrite, [14] memtoreg,
  // [13] link, [12] alusrc, [11] ir_write, [10] pc_write, [9:8] pc_sel,
  // [7:5] imm_type, [4:1] alucontrol, [0] error
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXE   = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [20:0] V_FETCH_ADV  = {S_FETCH, 8'b0100_0011, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [20:0] V_FETCH_WAIT = {S_FETCH, 8'b0100_0000, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [20:0] V_DEC        = {S_DEC,   8'b0000_0000, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [20:0] V_WB_ALU     = {S_WB,    8'b1000_0000, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [20:0] V_WB_LOAD    = {S_WB,    8'b1001_0000, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [20:0] V_MEM_LOAD   = {S_MEM,   8'b0100_0000, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [20:0] V_MEM_STORE  = {S_MEM,   8'b0010_0000, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [20:0] V_EXE_LOAD   = {S_EXE,   8'b0000_0100, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam logic [20:0] V_EXE_STORE  = {S_EXE,   8'b0000_0100, 2'd0, 3'd1, 4'd0, 1'b0};
  localparam logic [20:0] V_ERR        = {S_ERR,   8'b0000_0000, 2'd0, 3'd0, 4'd0, 1'b1};
  localparam logic [20:0] V_ZERO       = 21'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        zero;
  logic        lt;
  logic        mem_ready;
  wire  [20:0] obs_m;
  wire  [20:0] obs_t;
  wire  [20:0] obs_n;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_HANDSHAKE(1), .TIMEOUT_CYCLES(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .lt(lt),
    .mem_ready(mem_ready),
    .regwrite(obs_m[17]), .memread(obs_m[16]), .memwrite(obs_m[15]), .memtoreg(obs_m[14]),
    .link(obs_m[13]), .alusrc(obs_m[12]), .ir_write(obs_m[11]), .pc_write(obs_m[10]),
    .pc_sel(obs_m[9:8]), .imm_type(obs_m[7:5]), .alucontrol(obs_m[4:1]),
    .state_o(obs_m[20:18]), .error(obs_m[0])
  );

  multicycle_control_unit #(.MEM_HANDSHAKE(1), .TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .lt(lt),
    .mem_ready(1'b0),
    .regwrite(obs_t[17]), .memread(obs_t[16]), .memwrite(obs_t[15]), .memtoreg(obs_t[14]),
    .link(obs_t[13]), .alusrc(obs_t[12]), .ir_write(obs_t[11]), .pc_write(obs_t[10]),
    .pc_sel(obs_t[9:8]), .imm_type(obs_t[7:5]), .alucontrol(obs_t[4:1]),
    .state_o(obs_t[20:18]), .error(obs_t[0])
  );

  multicycle_control_unit #(.MEM_HANDSHAKE(0), .TIMEOUT_CYCLES(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero), .lt(lt),
    .mem_ready(1'b0),
    .regwrite(obs_n[17]), .memread(obs_n[16]), .memwrite(obs_n[15]), .memtoreg(obs_n[14]),
    .link(obs_n[13]), .alusrc(obs_n[12]), .ir_write(obs_n[11]), .pc_write(obs_n[10]),
    .pc_sel(obs_n[9:8]), .imm_type(obs_n[7:5]), .alucontrol(obs_n[4:1]),
    .state_o(obs_n[20:18]), .error(obs_n[0])
  );

  task automatic test_reset;
    rst_n = 1'b1; instruction = 32'h0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (obs_m !== V_ZERO) begin miscompares++; $display("FAIL reset_main got=%h want=%h", obs_m, V_ZERO); end
    vectors++;
    if (obs_t !== V_ZERO) begin miscompares++; $display("FAIL reset_timeout got=%h want=%h", obs_t, V_ZERO); end
    vectors++;
    if (obs_n !== V_ZERO) begin miscompares++; $display("FAIL reset_nohs got=%h want=%h", obs_n, V_ZERO); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu;
    logic [31:0] ins [3];
    logic [20:0] ex  [3];
    logic [20:0] exp_v;
    ins[0] = 32'h00A00613; ex[0] = {S_EXE, 8'b0000_0100, 2'd0, 3'd0, 4'd0,  1'b0};
    ins[1] = 32'h40B50533; ex[1] = {S_EXE, 8'b0000_0000, 2'd0, 3'd0, 4'd1,  1'b0};
    ins[2] = 32'h123452B7; ex[2] = {S_EXE, 8'b0000_0100, 2'd0, 3'd4, 4'd10, 1'b0};
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        instruction = ins[i]; mem_ready = 1'b1;
        case (c)
          0:       exp_v = V_FETCH_ADV;
          1:       exp_v = V_DEC;
          2:       exp_v = ex[i];
          default: exp_v = V_WB_ALU;
        endcase
        #1; vectors++;
        if (obs_m !== exp_v) begin
          miscompares++;
          $display("FAIL alu ins=%h cycle=%0d got=%h want=%h", ins[i], c, obs_m, exp_v);
        end
      end
    end
  endtask

  task automatic test_branch;
    logic [31:0] ins [4];
    logic        zv  [4];
    logic        lv  [4];
    logic [20:0] ex  [4];
    logic [20:0] exp_v;
    ins[0] = 32'h00060C63; zv[0] = 1'b1; lv[0] = 1'b0; ex[0] = {S_EXE, 8'b0000_0001, 2'd1, 3'd2, 4'd1, 1'b0};
    ins[1] = 32'h00060C63; zv[1] = 1'b0; lv[1] = 1'b0; ex[1] = {S_EXE, 8'b0000_0000, 2'd0, 3'd2, 4'd1, 1'b0};
    ins[2] = 32'h00065C63; zv[2] = 1'b1; lv[2] = 1'b0; ex[2] = {S_EXE, 8'b0000_0001, 2'd1, 3'd2, 4'd3, 1'b0};
    ins[3] = 32'h00066C63; zv[3] = 1'b0; lv[3] = 1'b0; ex[3] = {S_EXE, 8'b0000_0000, 2'd0, 3'd2, 4'd4, 1'b0};
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        instruction = ins[i]; zero = zv[i]; lt = lv[i]; mem_ready = 1'b1;
        exp_v = (c == 0) ? V_FETCH_ADV : (c == 1) ? V_DEC : ex[i];
        #1; vectors++;
        if (obs_m !== exp_v) begin
          miscompares++;
          $display("FAIL branch case=%0d cycle=%0d got=%h want=%h", i, c, obs_m, exp_v);
        end
      end
    end
    zero = 1'b0; lt = 1'b0;
  endtask

  task automatic test_jump;
    logic [31:0] ins [2];
    logic [20:0] ex  [2];
    logic [20:0] exp_v;
    ins[0] = 32'hFEDFF06F; ex[0] = {S_EXE, 8'b1000_1001, 2'd1, 3'd3, 4'd0, 1'b0};
    ins[1] = 32'h000500E7; ex[1] = {S_EXE, 8'b1000_1001, 2'd2, 3'd0, 4'd0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        instruction = ins[i]; mem_ready = 1'b1;
        exp_v = (c == 0) ? V_FETCH_ADV : (c == 1) ? V_DEC : ex[i];
        #1; vectors++;
        if (obs_m !== exp_v) begin
          miscompares++;
          $display("FAIL jump ins=%h cycle=%0d got=%h want=%h", ins[i], c, obs_m, exp_v);
        end
      end
    end
  endtask

  task automatic test_load_wait;
    logic        rdy [8];
    logic [20:0] ex  [8];
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ex  = '{V_FETCH_ADV, V_DEC, V_EXE_LOAD, V_MEM_LOAD, V_MEM_LOAD, V_MEM_LOAD, V_MEM_LOAD, V_WB_LOAD};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      instruction = 32'h00052283; mem_ready = rdy[c];
      #1; vectors++;
      if (obs_m !== ex[c]) begin
        miscompares++;
        $display("FAIL load_wait cycle=%0d got=%h want=%h", c, obs_m, ex[c]);
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_store;
    logic [20:0] ex [4];
    ex = '{V_FETCH_ADV, V_DEC, V_EXE_STORE, V_MEM_STORE};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      instruction = 32'h00C52223; mem_ready = 1'b1;
      #1; vectors++;
      if (obs_m !== ex[c]) begin
        miscompares++;
        $display("FAIL store cycle=%0d got=%h want=%h", c, obs_m, ex[c]);
      end
    end
  endtask

  task automatic test_no_handshake;
    logic [20:0] ex [4];
    ex = '{V_FETCH_ADV, V_DEC, V_EXE_STORE, V_MEM_STORE};
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      instruction = 32'h00C52223; mem_ready = 1'b1;
      #1; vectors++;
      if (obs_n !== ex[c]) begin
        miscompares++;
        $display("FAIL no_handshake cycle=%0d got=%h want=%h", c, obs_n, ex[c]);
      end
    end
  endtask

  task automatic test_timeout;
    logic [20:0] exp_v;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      instruction = 32'h00A00613; mem_ready = 1'b1;
      exp_v = (c < 4) ? V_FETCH_WAIT : V_ERR;
      #1; vectors++;
      if (obs_t !== exp_v) begin
        miscompares++;
        $display("FAIL timeout cycle=%0d got=%h want=%h", c, obs_t, exp_v);
      end
    end
    @(negedge clk); rst_n = 1'b0;
    #1; vectors++;
    if (obs_t !== V_ZERO) begin miscompares++; $display("FAIL timeout_exit got=%h want=%h", obs_t, V_ZERO); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_illegal;
    logic [20:0] ex [5];
    ex = '{V_FETCH_ADV, V_DEC, V_ERR, V_ERR, V_ERR};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      instruction = 32'h0000007F; mem_ready = 1'b1;
      #1; vectors++;
      if (obs_m !== ex[c]) begin
        miscompares++;
        $display("FAIL illegal cycle=%0d got=%h want=%h", c, obs_m, ex[c]);
      end
    end
    @(negedge clk); rst_n = 1'b0;
    #1; vectors++;
    if (obs_m !== V_ZERO) begin miscompares++; $display("FAIL illegal_exit got=%h want=%h", obs_m, V_ZERO); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_memory;
    logic        rdy [4];
    logic [20:0] ex  [4];
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    ex  = '{V_FETCH_ADV, V_DEC, V_EXE_LOAD, V_MEM_LOAD};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      instruction = 32'h00052283; mem_ready = rdy[c];
      #1; vectors++;
      if (obs_m !== ex[c]) begin
        miscompares++;
        $display("FAIL midmem cycle=%0d got=%h want=%h", c, obs_m, ex[c]);
      end
    end
    #2 rst_n = 1'b0;
    #1; vectors++;
    if (obs_m !== V_ZERO) begin miscompares++; $display("FAIL midmem_async got=%h want=%h", obs_m, V_ZERO); end
    @(negedge clk); rst_n = 1'b1;
    #1; vectors++;
    if (obs_m !== V_ZERO) begin miscompares++; $display("FAIL midmem_rst_state got=%h want=%h", obs_m, V_ZERO); end
    @(negedge clk); mem_ready = 1'b1;
    #1; vectors++;
    if (obs_m !== V_FETCH_ADV) begin miscompares++; $display("FAIL midmem_restart got=%h want=%h", obs_m, V_FETCH_ADV); end
    @(negedge clk);
    #1; vectors++;
    if (obs_m !== V_DEC) begin miscompares++; $display("FAIL midmem_decode got=%h want=%h", obs_m, V_DEC); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_load_wait();
    test_store();
    test_no_handshake();
    test_timeout();
    test_illegal();
    test_reset_mid_memory();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the combinational RV32I control unit. An FSM sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the same datapath control signals per state. It adds a parametrised memory ready-handshake, a wait-timeout, and an ERROR halt state. It sits between the instruction register and a shared-memory multi-cycle datapath that keeps the old PC alongside the IR.

Parameters:
MEM_HANDSHAKE, 1, 1 = FETCH/MEMORY wait for mem_ready; 0 = memory is single-cycle and mem_ready is ignored.
TIMEOUT_CYCLES, 0, maximum wait cycles in FETCH/MEMORY before ERROR; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
instruction  in  32  IR contents, stable from DECODE onward
zero  in  1  ALU zero flag, combinational in EXECUTE
lt  in  1  ALU SLT/SLTU result bit 0, combinational in EXECUTE
mem_ready  in  1  memory access complete this cycle
regwrite  out  1  register-file write enable
memread  out  1  memory read request
memwrite  out  1  memory write request
memtoreg  out  1  writeback source is memory data
link  out  1  writeback source is old_pc+4 (JAL/JALR)
alusrc  out  1  ALU B operand: 0 = rs2, 1 = immediate
ir_write  out  1  load IR and old_pc
pc_write  out  1  PC update enable
pc_sel  out  2  00 PC+4, 01 old_pc+imm, 10 (rs1+imm)&~1
imm_type  out  3  0 I, 1 S, 2 B, 3 J, 4 U
alucontrol  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
state_o  out  3  current state, for debug
error  out  1  halted in ERROR

Behaviour:
- Single clock domain; reset is asynchronous and active-low (clk, rst_n). Reset forces state RST and all outputs to 0 immediately, including mid-instruction. The first clk edge after rst_n rises moves RST→FETCH.
- Outputs are combinational from the state register and the decoded instruction. Every control signal not listed for a state is 0.
- FETCH: memread=1. Advance when mem_ready is high, or unconditionally if MEM_HANDSHAKE=0. In the advancing cycle: ir_write=1, pc_write=1, pc_sel=00.
- DECODE: no controls asserted. Illegal opcode or funct → ERROR. Otherwise → EXECUTE.
- EXECUTE controls by class:
  - R: alusrc=0, alucontrol per funct3/funct7[5].
  - I-ALU: alusrc=1, imm_type=I.
  - LOAD/STORE: ADD, alusrc=1, imm_type I or S.
  - LUI: PASS_B, alusrc=1, imm_type=U.
- EXECUTE next state: R, I-ALU and LUI → WRITEBACK; LOAD and STORE → MEMORY.
- BRANCH in EXECUTE:
  - imm_type=B, alusrc=0, alucontrol SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - Taken: BEQ zero, BNE !zero, BLT/BLTU lt, BGE/BGEU !lt.
  - If taken: pc_write=1, pc_sel=01. Then → FETCH.
- JAL/JALR in EXECUTE: regwrite=1, link=1, pc_write=1; pc_sel=01 with imm_type J (JAL) or pc_sel=10 with imm_type I (JALR). Then → FETCH.
- MEMORY: memread (LOAD) or memwrite (STORE) is held until mem_ready. On ready, LOAD → WRITEBACK and STORE → FETCH.
- WRITEBACK: regwrite=1, memtoreg=1 for LOAD. Then → FETCH.
- Cycle counts with zero wait: ALU/LUI 4, LOAD 5, STORE 4, BRANCH/JAL/JALR 3.
- Wait counter:
  - Cleared on entry to FETCH/MEMORY and increments each cycle without mem_ready.
  - When TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES with mem_ready still low → ERROR.
  - mem_ready in the same cycle as the count is reached wins: normal advance.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- ERROR: error=1, all other controls 0. Only rst_n exits ERROR.
- Legal opcodes: 0110011, 0010011, 0000011 (LW only), 0100011 (SW only), 1100011 (funct3 010/011 illegal), 1101111, 1100111 (funct3 000), 0110111.

Decomposition:
- Package cu_pkg holds: opcode localparams, the state_e, alu_op_e, imm_type_e and pc_sel_e enums, and an instr_class_e enum (R, I_ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, ILLEGAL).
- Sub-module cu_decoder (combinational) maps opcode/funct3/funct7 to class, alucontrol and imm_type.
- Top level holds the FSM, wait counter and per-state output gating.

Test Plan:
- ADDI 0x00A00613, mem_ready=1 → states FETCH, DECODE, EXECUTE, WRITEBACK. EXECUTE: alusrc=1, imm_type=0, alucontrol=0. WRITEBACK: regwrite=1, memtoreg=0. Back in FETCH at cycle 5.
- BEQ 0x00060C63, zero=1 → EXECUTE pc_write=1, pc_sel=01, imm_type=2, alucontrol=1. Rerun with zero=0 → pc_write=0. FETCH follows in both cases.
- JAL 0xFEDFF06F → EXECUTE regwrite=1, link=1, pc_write=1, pc_sel=01, imm_type=3, then FETCH.
- LW 0x00052283 with mem_ready low for 3 MEMORY cycles → memread held 4 cycles, 8 cycles total. WRITEBACK has regwrite=1, memtoreg=1.
- TIMEOUT_CYCLES=4, mem_ready tied 0 → ERROR after 4 FETCH wait cycles, error=1, stays until rst_n.
- Opcode 0x0000007F → ERROR after DECODE. Separately, assert rst_n=0 mid-MEMORY → all outputs 0 the same cycle, and the FSM restarts via RST→FETCH.
